// File: rtl/module_leds_driver_if.sv
// LED driver bus: the logical pattern and mode controls go in, and the
// physical LED pins and blink tick come out.
interface module_leds_driver_if #(
  parameter int N_LEDS   = 6,
  parameter int PWM_BITS = 4
);
  logic [N_LEDS-1:0]   binario;
  logic [1:0]          modo;
  logic [PWM_BITS-1:0] brillo;
  logic                error_i;
  logic                tick_o;
  logic [N_LEDS-1:0]   led;

  // Side that supplies the pattern and controls (decoder / top level).
  modport master (
    output binario, modo, brillo, error_i,
    input  tick_o, led
  );

  // LED driver side.
  modport slave (
    input  binario, modo, brillo, error_i,
    output tick_o, led
  );
endinterface

// File: rtl/module_leds_driver.sv
// LED output stage: direct, blink, PWM-dimmed and chase modes, plus an
// error-flash override. Every output is registered, so the pins change
// one cycle after the inputs are sampled.
module module_leds_driver #(
  parameter int N_LEDS     = 6,
  parameter int ACTIVE_LOW = 1,
  parameter int CLK_HZ     = 27_000_000,
  parameter int BLINK_HZ   = 2,
  parameter int PWM_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  module_leds_driver_if.slave   bus
);

  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int PRE_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int POS_W     = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);
  localparam logic [N_LEDS-1:0] LED_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [PRE_W-1:0]    presc_reg;
  logic                phase_reg;
  logic                tick_reg;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [POS_W-1:0]    pos_reg;
  logic [1:0]          modo_prev_reg;
  logic [N_LEDS-1:0]   led_reg;

  logic                terminal;
  logic                entering_chase;
  logic                pwm_on;
  logic [N_LEDS-1:0]   onehot_next;
  logic [N_LEDS-1:0]   pattern_next;

  assign terminal       = (presc_reg == PRE_LAST);
  assign entering_chase = (bus.modo == 2'b11) && (modo_prev_reg != 2'b11);
  // All-ones duty means fully on, so the last PWM slot is not lost.
  assign pwm_on         = (pwm_cnt_reg < bus.brillo) || (&bus.brillo);

  // On the cycle chase mode is entered, show bit 0 rather than a stale position.
  generate
    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_onehot
      assign onehot_next[gi] = entering_chase ? (gi == 0) : (pos_reg == POS_W'(gi));
    end
  endgenerate

  // Logical pattern (1 = lit) for the current inputs and timing state.
  always_comb begin
    pattern_next = '0;
    if (bus.error_i) begin
      pattern_next = phase_reg ? '0 : '1;
    end else begin
      case (bus.modo)
        2'b00:   pattern_next = bus.binario;
        2'b01:   pattern_next = phase_reg ? '0 : bus.binario;
        2'b10:   pattern_next = pwm_on ? bus.binario : '0;
        default: pattern_next = onehot_next;
      endcase
    end
  end

  // Free-running blink prescaler, phase flip-flop, tick pulse and PWM counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg   <= '0;
      phase_reg   <= 1'b0;
      tick_reg    <= 1'b0;
      pwm_cnt_reg <= '0;
    end else begin
      presc_reg   <= terminal ? '0 : presc_reg + 1'b1;
      phase_reg   <= terminal ? ~phase_reg : phase_reg;
      tick_reg    <= terminal;
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
    end
  end

  // Chase position: frozen during error flash, restarted on entering chase mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_reg       <= '0;
      modo_prev_reg <= 2'b00;
    end else begin
      modo_prev_reg <= bus.modo;
      if (!bus.error_i) begin
        if (entering_chase) begin
          pos_reg <= '0;
        end else if ((bus.modo == 2'b11) && terminal) begin
          pos_reg <= (pos_reg == POS_LAST) ? '0 : pos_reg + 1'b1;
        end
      end
    end
  end

  // Output register with board polarity applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg <= LED_OFF;
    end else begin
      led_reg <= (ACTIVE_LOW != 0) ? ~pattern_next : pattern_next;
    end
  end

  assign bus.led    = led_reg;
  assign bus.tick_o = tick_reg;

endmodule
